// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command queue.
package cmd_pkg;

  typedef logic [15:0] cmd_word_t;

  localparam logic [7:0] ACK_BYTE_C = 8'hA5;
  localparam logic [7:0] NAK_BYTE_C = 8'hEE;

  localparam int TO_W_SLOW = 24;
  localparam int TO_W_FAST = 12;

  typedef enum logic [1:0] {
    OP_STOP   = 2'b00,
    OP_VEER_R = 2'b01,
    OP_VEER_L = 2'b10,
    OP_TURN   = 2'b11
  } cmd_op_e;

  typedef enum logic {S_HIGH = 1'b0, S_LOW = 1'b1} asm_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rsp_state_e;

  // The maneuver code sits in the top two bits of a command word.
  function automatic cmd_op_e cmd_op(input cmd_word_t w);
    return cmd_op_e'(w[15:14]);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with a registered head word; a pop and a push may
// share a cycle even when full.
module cmd_fifo
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  cmd_word_t                i_din,
  input  logic                     i_pop,
  output cmd_word_t                o_head,
  output logic                     o_vld,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_push_ok
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ZERO_C  = (PW+1)'(0);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_cnt;
  cmd_word_t     r_mem [DEPTH];
  cmd_word_t     r_head;

  logic          w_pop_ok;
  logic          w_push_ok;
  logic [PW-1:0] w_rd_nxt;
  logic [PW:0]   w_cnt_after_pop;
  logic [PW:0]   w_cnt_nxt;
  cmd_word_t     w_head_nxt;

  assign w_pop_ok        = i_pop && (r_cnt != ZERO_C);
  assign w_push_ok       = i_push && ((r_cnt != DEPTH_C) || w_pop_ok);
  assign w_rd_nxt        = r_rd_ptr + PW'(w_pop_ok);
  assign w_cnt_after_pop = r_cnt - (PW+1)'(w_pop_ok);
  assign w_cnt_nxt       = w_cnt_after_pop + (PW+1)'(w_push_ok);
  // A push into an (effectively) empty queue bypasses storage to the head.
  assign w_head_nxt      = (w_push_ok && (w_cnt_after_pop == ZERO_C)) ? i_din : r_mem[w_rd_nxt];

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= ZERO_C;
      r_head   <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 16'h0000;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= ZERO_C;
      r_head   <= 16'h0000;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_head   <= w_head_nxt;
    end
  end

  assign o_head    = r_head;
  assign o_vld     = (r_cnt != ZERO_C);
  assign o_full    = (r_cnt == DEPTH_C);
  assign o_cnt     = r_cnt;
  assign o_push_ok = w_push_ok && !i_clr;

endmodule

// File: rtl/cmd_queue_ctrl.sv
// Assembles UART byte pairs into command words, queues them for cmd_proc and
// answers each completed word with an ACK or NAK byte.
module cmd_queue_ctrl
  import cmd_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter bit         FAST_SIM = 1'b0,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_C,
  parameter logic [7:0] NAK_BYTE = NAK_BYTE_C
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_rdy,
  input  logic [7:0]             i_rx_data,
  output logic                   o_clr_rx_rdy,
  output logic [15:0]            o_cmd,
  output logic                   o_cmd_vld,
  input  logic                   i_cmd_taken,
  input  logic                   i_flush,
  output logic                   o_trmt,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_done,
  output logic                   o_q_full,
  output logic [$clog2(DEPTH):0] o_q_cnt
);

  localparam int TO_W = FAST_SIM ? TO_W_FAST : TO_W_SLOW;

  asm_state_e    r_asm, w_asm_nxt;
  logic [7:0]    r_high;
  logic [TO_W-1:0] r_to_cnt;
  logic          r_clr_rx_rdy;
  logic          w_take, w_to_done, w_high_ld, w_push_req, w_push, w_push_ok;

  rsp_state_e    r_rsp_st, w_rsp_nxt;
  logic [1:0]    r_rsp_q, w_q_nxt;
  logic [1:0]    r_rsp_n, w_n_nxt;
  logic          w_send;
  logic          r_trmt;
  logic [7:0]    r_tx_data;

  // The clr pulse is still high the cycle after a take, so skip that cycle.
  assign w_take    = i_rx_rdy && !r_clr_rx_rdy;
  assign w_to_done = (r_to_cnt == {TO_W{1'b1}});
  assign w_push    = w_push_req && !i_flush;

  // Byte assembly next-state.
  always_comb begin
    w_asm_nxt  = r_asm;
    w_high_ld  = 1'b0;
    w_push_req = 1'b0;
    case (r_asm)
      S_HIGH: begin
        if (w_take) begin
          w_high_ld = 1'b1;
          w_asm_nxt = S_LOW;
        end else begin
          w_asm_nxt = S_HIGH;
        end
      end
      S_LOW: begin
        if (w_take) begin
          w_push_req = 1'b1;
          w_asm_nxt  = S_HIGH;
        end else if (w_to_done) begin
          w_asm_nxt  = S_HIGH;
        end else begin
          w_asm_nxt  = S_LOW;
        end
      end
      default: w_asm_nxt = S_HIGH;
    endcase
    if (i_flush) begin
      w_asm_nxt = S_HIGH;
    end else begin
      w_asm_nxt = w_asm_nxt;
    end
  end

  // Byte assembly state, high byte, inter-byte timeout and rx consume pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm        <= S_HIGH;
      r_high       <= 8'h00;
      r_to_cnt     <= '0;
      r_clr_rx_rdy <= 1'b0;
    end else begin
      r_asm        <= w_asm_nxt;
      r_clr_rx_rdy <= w_take;
      if (i_flush) begin
        r_high <= 8'h00;
      end else if (w_high_ld) begin
        r_high <= i_rx_data;
      end else begin
        r_high <= r_high;
      end
      if ((r_asm == S_LOW) && (w_asm_nxt == S_LOW)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_flush),
    .i_push    (w_push),
    .i_din     ({r_high, i_rx_data}),
    .i_pop     (i_cmd_taken),
    .o_head    (o_cmd),
    .o_vld     (o_cmd_vld),
    .o_full    (o_q_full),
    .o_cnt     (o_q_cnt),
    .o_push_ok (w_push_ok)
  );

  assign w_send = (r_rsp_st == R_IDLE) && (r_rsp_n != 2'd0);

  // Response FSM next-state and pending-response queue (1 = ACK, 0 = NAK).
  always_comb begin
    w_rsp_nxt = r_rsp_st;
    w_q_nxt   = r_rsp_q;
    w_n_nxt   = r_rsp_n;
    case (r_rsp_st)
      R_IDLE:  w_rsp_nxt = w_send ? R_BUSY : R_IDLE;
      R_BUSY:  w_rsp_nxt = i_tx_done ? R_IDLE : R_BUSY;
      default: w_rsp_nxt = R_IDLE;
    endcase
    if (w_send) begin
      w_q_nxt = {1'b0, r_rsp_q[1]};
      w_n_nxt = r_rsp_n - 2'd1;
    end else begin
      w_n_nxt = r_rsp_n;
    end
    // With both slots occupied the newest entry is overwritten.
    if (w_push) begin
      case (w_n_nxt)
        2'd0: begin
          w_q_nxt[0] = w_push_ok;
          w_n_nxt    = 2'd1;
        end
        2'd1: begin
          w_q_nxt[1] = w_push_ok;
          w_n_nxt    = 2'd2;
        end
        default: w_q_nxt[1] = w_push_ok;
      endcase
    end else begin
      w_n_nxt = w_n_nxt;
    end
  end

  // Response state, pending queue and registered transmit outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_st  <= R_IDLE;
      r_rsp_q   <= 2'b00;
      r_rsp_n   <= 2'd0;
      r_trmt    <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_rsp_st <= w_rsp_nxt;
      r_rsp_q  <= w_q_nxt;
      r_rsp_n  <= w_n_nxt;
      r_trmt   <= w_send;
      if (w_send) begin
        r_tx_data <= r_rsp_q[0] ? ACK_BYTE : NAK_BYTE;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  assign o_clr_rx_rdy = r_clr_rx_rdy;
  assign o_trmt       = r_trmt;
  assign o_tx_data    = r_tx_data;

endmodule
